alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, handshaked successor to the 32-bit AND/OR/ADD ALU. Keeps the binvert/cin
//  operand path and adds NOR, SLT and an iterative shift-add multiply. Registers the result
//  with status flags. Sits between operand fetch and writeback in the lab datapath.
// PARAMETERS
//  WIDTH   32  operand/result width in bits (>=4)
//  CNT_W   $clog2(WIDTH+1)  multiply iteration counter width (derived, do not override)
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  reset      in   1      synchronous, active-high
//  in_valid   in   1      operands/op valid this cycle
//  in_ready   out  1      block accepts operands this cycle
//  op         in   3      000 AND, 001 OR, 010 ADD, 011 SLT, 100 MUL, 101 NOR, 11x reserved
//  binvert    in   1      use ~in2 instead of in2 (AND/OR/ADD/SLT/NOR; ignored for MUL)
//  cin        in   1      adder carry-in (ADD/SLT; ignored otherwise)
//  in1        in   WIDTH  operand A
//  in2        in   WIDTH  operand B
//  out_valid  out  1      result valid, held until out_ready
//  out_ready  in   1      consumer takes result
//  ans        out  WIDTH  result
//  cout       out  1      adder carry-out (ADD/SLT), else 0
//  ovf        out  1      signed overflow of in1+b+cin (ADD/SLT), else 0
//  zero       out  1      ans == 0
// BEHAVIOUR
//  - Reset: state IDLE; out_valid=0, ans=0, cout=0, ovf=0, zero=1; mul counter/accumulator cleared.
//  - Transfer rules: input accepted when in_valid&&in_ready; output consumed when out_valid&&out_ready.
//  - in_ready = (state==IDLE) && (!out_valid || out_ready); output drained and new op accepted same cycle.
//  - b = binvert ? ~in2 : in2; sum = in1 + b + cin computed at WIDTH+1 bits; cout = sum[WIDTH].
//  - ovf = (in1[MSB]==b[MSB]) && (sum[MSB]!=in1[MSB]).
//  - SLT: ans = {WIDTH-1 zeros, sum[MSB]^ovf}; caller sets binvert=1,cin=1 for signed compare.
//  - Single-cycle ops (AND/OR/ADD/SLT/NOR): accepted at edge N -> out_valid=1 with result after edge N.
//  - Reserved op: treated as single-cycle, ans=0, cout=0, ovf=0, zero=1.
//  - MUL: IDLE->MUL on accept; latch multiplicand=in1, multiplier=in2, acc=0, cnt=0.
//    Each MUL cycle: if multiplier[0] acc+=multiplicand; multiplicand<<=1; multiplier>>=1; cnt++.
//    After WIDTH iterations -> IDLE with out_valid=1, ans=acc (low WIDTH bits, unsigned wrap).
//    Latency accept->out_valid = WIDTH edges; in_ready=0 throughout MUL.
//  - State machine: IDLE -(accept MUL)-> MUL -(cnt==WIDTH-1)-> IDLE. No other states.
//  - Output regs (ans,cout,ovf,zero) change only when a new result is loaded; stable while
//    out_valid&&!out_ready (backpressure holds indefinitely).
//  - out_valid clears on consume unless a new single-cycle result loads the same edge.
//  - reset mid-MUL: abandon op, return to reset values next edge; no partial result emitted.
//  - in_valid while in_ready=0: ignored (not queued); source must hold.
// STRUCTURE
//  - Package alu_pkg: op encodings (OP_AND..OP_NOR) as localparams, state enum {IDLE, MUL}.
//  - One sub-module: alu_addsub_core (WIDTH): comb b-invert, adder, cout, ovf; shared by ADD/SLT.
//  - Multiply datapath, FSM, output register in alu_seq itself.
// TESTING (WIDTH=32, out_ready=1 unless noted)
//  - ADD 0xFFFFFFFF+0x00000001,cin=0 -> ans=0, cout=1, zero=1, ovf=0, out_valid one edge after accept.
//  - SUB(binvert=1,cin=1) 0x80000000-0x00000001 -> ans=0x7FFFFFFF, ovf=1, cout=1.
//  - SLT(binvert=1,cin=1) in1=0xFFFFFFFE(-2), in2=0x00000003 -> ans=1; swapped -> ans=0.
//  - MUL 0x00012345*0x00000100 -> ans=0x01234500 after 32 edges; in_ready=0 for all 32 cycles.
//  - Backpressure: out_ready=0 for 5 cycles after AND 0xF0F0F0F0&0xFF00FF00 -> ans=0xF000F000 held,
//    in_ready=0; raise out_ready with new OR pending -> consume and accept same edge.
//  - Reset asserted at MUL cycle 10 -> next edge out_valid=0, ans=0, zero=1, in_ready=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings and FSM state type.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  function automatic logic is_mul(input logic [2:0] op);
    return op == OP_MUL;
  endfunction

endpackage

// File: rtl/alu_addsub_core.sv
// Combinational operand path: optional B inversion, adder with carry-in, carry-out and signed overflow.
module alu_addsub_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             binvert,
  input  logic             cin,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH:0] sum_ext;

  always_comb begin
    b       = binvert ? ~in2 : in2;
    sum_ext = {1'b0, in1} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    sum     = sum_ext[WIDTH-1:0];
    cout    = sum_ext[WIDTH];
    ovf     = (in1[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != in1[WIDTH-1]);
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle AND/OR/ADD/SLT/NOR plus an iterative shift-add multiply,
// with a registered result and status flags held under backpressure.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             binvert,
  input  logic             cin,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ans,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t state, state_next;

  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic             add_cout;
  logic             add_ovf;

  logic [WIDTH-1:0] res_ans;
  logic             res_cout;
  logic             res_ovf;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] cnt;

  logic accept;
  logic consume;
  logic mul_done;

  alu_addsub_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .in1    (in1),
    .in2    (in2),
    .binvert(binvert),
    .cin    (cin),
    .b      (b),
    .sum    (sum),
    .cout   (add_cout),
    .ovf    (add_ovf)
  );

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;
  assign mul_done = (state == MUL) && (cnt == LAST_ITER);
  assign acc_next = mplier[0] ? acc + mcand : acc;

  // Single-cycle result; reserved opcodes fall through to all-zero with no flags.
  always_comb begin
    res_ans  = '0;
    res_cout = 1'b0;
    res_ovf  = 1'b0;
    case (op)
      OP_AND: res_ans = in1 & b;
      OP_OR:  res_ans = in1 | b;
      OP_NOR: res_ans = ~(in1 | b);
      OP_ADD: begin
        res_ans  = sum;
        res_cout = add_cout;
        res_ovf  = add_ovf;
      end
      OP_SLT: begin
        res_ans  = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
        res_cout = add_cout;
        res_ovf  = add_ovf;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept && is_mul(op)) state_next = MUL;
      MUL:  if (mul_done)             state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A consume and a new load on the same edge leave out_valid set: the load wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      ans       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b1;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      if (consume) out_valid <= 1'b0;

      if (accept) begin
        if (is_mul(op)) begin
          mcand  <= in1;
          mplier <= in2;
          acc    <= '0;
          cnt    <= '0;
        end else begin
          out_valid <= 1'b1;
          ans       <= res_ans;
          cout      <= res_cout;
          ovf       <= res_ovf;
          zero      <= (res_ans == '0);
        end
      end

      if (state == MUL) begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CNT_W'(1);
        if (mul_done) begin
          out_valid <= 1'b1;
          ans       <= acc_next;
          cout      <= 1'b0;
          ovf       <= 1'b0;
          zero      <= (acc_next == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed vectors push expected results, a monitor checks each transfer.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int WIDTH = 32;

  typedef struct packed {
    logic [WIDTH-1:0] ans;
    logic             cout;
    logic             ovf;
    logic             zero;
  } res_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic             binvert;
  logic             cin;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ans;
  logic             cout;
  logic             ovf;
  logic             zero;

  res_t  exp_q[$];
  string name_q[$];
  res_t  mon_e;
  string mon_n;
  int    checks = 0;
  int    errors = 0;
  int    waited;

  alu_seq #(
    .WIDTH(WIDTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .binvert  (binvert),
    .cin      (cin),
    .in1      (in1),
    .in2      (in2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ans      (ans),
    .cout     (cout),
    .ovf      (ovf),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  function automatic res_t r(input logic [WIDTH-1:0] a, input logic c, input logic o, input logic z);
    r = '{ans: a, cout: c, ovf: o, zero: z};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Monitor: a transfer happens at the next rising edge when out_valid && out_ready.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got ans=%h, required no result", ans);
        end else begin
          mon_e = exp_q.pop_front();
          mon_n = name_q.pop_front();
          if ({ans, cout, ovf, zero} !== mon_e) begin
            errors++;
            $display("FAIL %s: got ans=%h cout=%b ovf=%b zero=%b, required ans=%h cout=%b ovf=%b zero=%b",
                     mon_n, ans, cout, ovf, zero, mon_e.ans, mon_e.cout, mon_e.ovf, mon_e.zero);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drive one operation and hold it until accepted; returns just after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic bi, input logic ci,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] bb,
                       input bit push, input res_t e, input string nm, output int w);
    op = o; binvert = bi; cin = ci; in1 = a; in2 = bb; in_valid = 1'b1;
    w = 0;
    #1;
    while (in_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: got in_ready=%b, required 1 within 200 cycles", nm, in_ready);
      in_valid = 1'b0;
      return;
    end
    if (push) begin
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic single(input logic [2:0] o, input logic bi, input logic ci,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] bb,
                        input res_t e, input string nm);
    int w;
    issue(o, bi, ci, a, bb, 1'b1, e, nm, w);
    @(negedge clk);
    #1;
    check({nm, "_latency"}, {31'b0, out_valid}, 32'd1);
  endtask

  task automatic mul(input logic bi, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] bb,
                     input res_t e, input string nm);
    int w;
    issue(OP_MUL, bi, 1'b0, a, bb, 1'b1, e, nm, w);
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clk);
      #1;
      check({nm, "_busy"}, {30'b0, in_ready, out_valid}, 32'd0);
    end
    @(negedge clk);
    #1;
    check({nm, "_latency"}, {31'b0, out_valid}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = OP_AND; binvert = 1'b0; cin = 1'b0; in1 = '0; in2 = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_ans", ans, 32'd0);
    check("reset_flags", {29'b0, cout, ovf, zero}, 32'd1);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    single(OP_ADD, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, r(32'h0000_0000, 1'b1, 1'b0, 1'b1), "add_wrap");
    single(OP_ADD, 1'b1, 1'b1, 32'h8000_0000, 32'h0000_0001, r(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0), "sub_ovf");
    single(OP_SLT, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'h0000_0003, r(32'h0000_0001, 1'b1, 1'b0, 1'b0), "slt_true");
    single(OP_SLT, 1'b1, 1'b1, 32'h0000_0003, 32'hFFFF_FFFE, r(32'h0000_0000, 1'b0, 1'b0, 1'b1), "slt_false");
    single(OP_ADD, 1'b0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, r(32'h8000_0000, 1'b0, 1'b1, 1'b0), "add_pos_ovf");
    single(OP_ADD, 1'b0, 1'b1, 32'h0000_0005, 32'h0000_0006, r(32'h0000_000C, 1'b0, 1'b0, 1'b0), "add_cin");
    single(OP_NOR, 1'b0, 1'b0, 32'h0F0F_0F0F, 32'hF0F0_F000, r(32'h0000_00F0, 1'b0, 1'b0, 1'b0), "nor");
    single(OP_NOR, 1'b1, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF, r(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0), "nor_binv");
    single(OP_OR,  1'b1, 1'b0, 32'h1234_0000, 32'hFFFF_0000, r(32'h1234_FFFF, 1'b0, 1'b0, 1'b0), "or_binv");
    single(OP_AND, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, r(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0), "and_noflags");
    single(3'b110, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r(32'h0000_0000, 1'b0, 1'b0, 1'b1), "reserved_110");
    single(3'b111, 1'b1, 1'b1, 32'h0000_0001, 32'h0000_0001, r(32'h0000_0000, 1'b0, 1'b0, 1'b1), "reserved_111");

    mul(1'b0, 32'h0001_2345, 32'h0000_0100, r(32'h0123_4500, 1'b0, 1'b0, 1'b0), "mul_basic");
    mul(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r(32'h0000_0001, 1'b0, 1'b0, 1'b0), "mul_wrap");
    mul(1'b0, 32'h0000_0000, 32'h0000_DEAD, r(32'h0000_0000, 1'b0, 1'b0, 1'b1), "mul_zero");
    mul(1'b1, 32'h0000_0003, 32'h0000_0005, r(32'h0000_000F, 1'b0, 1'b0, 1'b0), "mul_binv_ignored");

    // Backpressure: result must hold while out_ready is low, then drain and accept on one edge.
    @(negedge clk);
    out_ready = 1'b0;
    issue(OP_AND, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1,
          r(32'hF000_F000, 1'b0, 1'b0, 1'b0), "bp_and", waited);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      check("bp_hold_ans", ans, 32'hF000_F000);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    issue(OP_OR, 1'b0, 1'b0, 32'h0000_000F, 32'h0000_00F0, 1'b1,
          r(32'h0000_00FF, 1'b0, 1'b0, 1'b0), "bp_or", waited);
    check("bp_same_edge_accept", waited, 32'd0);
    @(negedge clk);
    #1;
    check("bp_or_latency", {31'b0, out_valid}, 32'd1);

    // Reset mid-multiply: nothing from the abandoned op may appear.
    @(negedge clk);
    issue(OP_MUL, 1'b0, 1'b0, 32'h0001_2345, 32'h0000_0100, 1'b0, '0, "mul_abort", waited);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_mid_ans", ans, 32'd0);
    check("rst_mid_zero", {31'b0, zero}, 32'd1);
    check("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (40) @(negedge clk);
    #1;
    check("rst_no_partial", {31'b0, out_valid}, 32'd0);

    @(negedge clk);
    single(OP_ADD, 1'b0, 1'b0, 32'h0000_0010, 32'h0000_0020, r(32'h0000_0030, 1'b0, 1'b0, 1'b0), "add_after_rst");

    repeat (4) @(negedge clk);
    check("scoreboard_drain", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
